// File: rtl/can_rx_framer.sv
// can_rx_framer: CAN 2.0A bit-level receiver with hard sync, destuffing,
// CRC-15 check, ACK request and 108-bit frame packing for the RX queue.
module can_rx_framer #(
  parameter int CLK_PER_BIT = 100,
  parameter int SAMPLE_PT   = 70
) (
  input  logic         GCLK,
  input  logic         RES,
  input  logic         can_rx,
  input  logic         q_full,
  output logic [107:0] rx_frame,
  output logic         rx_push,
  output logic         ack_drive,
  output logic         bus_idle,
  output logic         stuff_err,
  output logic         crc_err,
  output logic         form_err,
  output logic         drop_ovf
);
  localparam int CW = $clog2(CLK_PER_BIT);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_SOF, S_ID, S_RTR, S_IDE, S_R0,
    S_DLC, S_DATA, S_CRC, S_CDEL, S_ACK, S_ADEL, S_EOF
  } st_t;

  st_t st, st_n;

  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [3:0]    idle_cnt;
  logic [2:0]    run;
  logic          last;
  logic [6:0]    fcnt, dlen;
  logic [10:0]   id;
  logic          rtr;
  logic [3:0]    dlc, dlc_n;
  logic [63:0]   data;
  logic [14:0]   crc_rx, crc, crc_n;
  logic          crc_ok;
  logic          smp, bitv, fall;
  logic          in_stf, in_crc, is_stuff, take;

  assign smp    = cnt == CW'(SAMPLE_PT);
  assign bitv   = rx_s2;
  assign fall   = (st == S_WAIT) && rx_d && !rx_s2;
  assign in_stf = st inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0,
                             S_DLC, S_DATA, S_CRC, S_CDEL};
  assign in_crc = st inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0,
                             S_DLC, S_DATA};
  // A trailing stuff bit after the CRC field lands in S_CDEL
  assign is_stuff = in_stf && (run == 3'd5);
  assign take     = smp && !is_stuff;

  assign dlc_n = {dlc[2:0], bitv};
  assign dlen  = dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000};
  assign crc_n = {crc[13:0], 1'b0} ^
                 ((bitv ^ crc[14]) ? 15'h4599 : 15'h0000);

  assign rx_frame = {id, rtr, dlc, data, crc_rx, 13'h0000};

  // ACK state spans the CDEL tail plus the ACK bit up to its sample
  assign ack_drive = crc_ok &&
    (((st == S_ACK) && (cnt <= CW'(SAMPLE_PT))) ||
     ((st == S_ADEL) && (cnt > CW'(SAMPLE_PT))));

  always_ff @(posedge GCLK or negedge RES) begin
    if (!RES) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= can_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  always_ff @(posedge GCLK or negedge RES) begin
    if (!RES) begin
      cnt <= '0;
    end else if (fall) begin
      cnt <= CW'(1);
    end else if (cnt == CW'(CLK_PER_BIT - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge GCLK or negedge RES) begin
    if (!RES) st <= S_IDLE;
    else      st <= st_n;
  end

  always_comb begin
    st_n      = st;
    rx_push   = 1'b0;
    stuff_err = 1'b0;
    crc_err   = 1'b0;
    form_err  = 1'b0;
    drop_ovf  = 1'b0;
    if (smp && is_stuff) begin
      if (bitv == last) begin
        stuff_err = 1'b1;
        st_n      = S_IDLE;
      end
    end else begin
      unique case (st)
        S_IDLE:
          if (smp && bitv && idle_cnt == 4'd10) st_n = S_WAIT;
        S_WAIT:
          if (fall) st_n = S_SOF;
        S_SOF:
          if (take) st_n = bitv ? S_WAIT : S_ID;
        S_ID:
          if (take && fcnt == 7'd10) st_n = S_RTR;
        S_RTR:
          if (take) st_n = S_IDE;
        S_IDE:
          if (take) st_n = bitv ? S_IDLE : S_R0;
        S_R0:
          if (take) st_n = S_DLC;
        S_DLC:
          if (take && fcnt == 7'd3)
            st_n = (rtr || dlc_n == 4'd0) ? S_CRC : S_DATA;
        S_DATA:
          if (take && fcnt == dlen - 7'd1) st_n = S_CRC;
        S_CRC:
          if (take && fcnt == 7'd14) st_n = S_CDEL;
        S_CDEL:
          if (take) begin
            if (bitv) begin
              st_n = S_ACK;
            end else begin
              form_err = 1'b1;
              st_n     = S_IDLE;
            end
          end
        S_ACK:
          if (smp) st_n = S_ADEL;
        S_ADEL:
          if (smp) begin
            if (!crc_ok) begin
              crc_err = 1'b1;
              st_n    = S_IDLE;
            end else if (!bitv) begin
              form_err = 1'b1;
              st_n     = S_IDLE;
            end else begin
              st_n = S_EOF;
            end
          end
        S_EOF:
          if (smp) begin
            if (!bitv) begin
              form_err = 1'b1;
              st_n     = S_IDLE;
            end else if (fcnt == 7'd6) begin
              rx_push  = !q_full;
              drop_ovf = q_full;
              st_n     = S_WAIT;
            end
          end
        default: st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge GCLK or negedge RES) begin
    if (!RES) begin
      idle_cnt <= '0;
      bus_idle <= 1'b0;
    end else if (fall) begin
      idle_cnt <= '0;
      bus_idle <= 1'b0;
    end else if (st != S_IDLE && st != S_WAIT) begin
      idle_cnt <= '0;
    end else if (smp) begin
      if (!bitv)                   idle_cnt <= '0;
      else if (idle_cnt != 4'd11)  idle_cnt <= idle_cnt + 4'd1;
      if (bitv && idle_cnt == 4'd10) bus_idle <= 1'b1;
    end
  end

  always_ff @(posedge GCLK or negedge RES) begin
    if (!RES) begin
      run    <= '0;
      last   <= 1'b1;
      fcnt   <= '0;
      crc    <= '0;
      crc_ok <= 1'b0;
      id     <= '0;
      rtr    <= 1'b0;
      dlc    <= '0;
      data   <= '0;
      crc_rx <= '0;
    end else if (fall) begin
      run    <= '0;
      last   <= 1'b1;
      fcnt   <= '0;
      crc    <= '0;
      crc_ok <= 1'b0;
      id     <= '0;
      rtr    <= 1'b0;
      dlc    <= '0;
      data   <= '0;
      crc_rx <= '0;
    end else begin
      if (st_n != st) fcnt <= '0;
      else if (take)  fcnt <= fcnt + 7'd1;
      if (smp && is_stuff) begin
        run  <= 3'd1;
        last <= bitv;
      end else if (take && in_stf) begin
        run  <= (bitv == last) ? run + 3'd1 : 3'd1;
        last <= bitv;
      end
      if (take && in_crc) crc <= crc_n;
      if (take) begin
        unique case (1'b1)
          st == S_ID:   id   <= {id[9:0], bitv};
          st == S_RTR:  rtr  <= bitv;
          st == S_DLC:  dlc  <= dlc_n;
          st == S_DATA: data[6'd63 - fcnt[5:0]] <= bitv;
          st == S_CRC: begin
            crc_rx <= {crc_rx[13:0], bitv};
            if (fcnt == 7'd14)
              crc_ok <= ({crc_rx[13:0], bitv} == crc);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_can_rx_framer.sv
// tb_can_rx_framer: directed CAN frames; expected events queued by the
// stimulus and matched by a monitor on every output pulse.
module tb_can_rx_framer;
  localparam int CPB = 12;
  localparam int SPT = 7;
  localparam int EV_PUSH  = 0;
  localparam int EV_STUFF = 1;
  localparam int EV_CRC   = 2;
  localparam int EV_FORM  = 3;
  localparam int EV_DROP  = 4;

  logic         GCLK = 1'b0;
  logic         RES = 1'b0;
  logic         can_rx = 1'b1;
  logic         q_full = 1'b0;
  logic [107:0] rx_frame;
  logic         rx_push, ack_drive, bus_idle;
  logic         stuff_err, crc_err, form_err, drop_ovf;

  can_rx_framer #(.CLK_PER_BIT(CPB), .SAMPLE_PT(SPT)) dut (
    .GCLK(GCLK), .RES(RES), .can_rx(can_rx), .q_full(q_full),
    .rx_frame(rx_frame), .rx_push(rx_push), .ack_drive(ack_drive),
    .bus_idle(bus_idle), .stuff_err(stuff_err), .crc_err(crc_err),
    .form_err(form_err), .drop_ovf(drop_ovf)
  );

  always #5 GCLK = ~GCLK;

  typedef struct {
    int           kind;
    logic [107:0] frame;
  } ev_t;

  ev_t          sb[$];
  string        sb_nm[$];
  bit           tx[$];
  logic [14:0]  good_crc;
  int           passed = 0;
  int           total = 0;
  int           ack_cyc = 0;

  task automatic check(input string nm, input logic [107:0] act,
                       input logic [107:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  task automatic expect_ev(input string nm, input int k,
                           input logic [107:0] f);
    ev_t e;
    e.kind  = k;
    e.frame = f;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic monitor();
    ev_t   e;
    string nm;
    int    k;
    forever begin
      @(negedge GCLK);
      if (ack_drive) ack_cyc++;
      if (rx_push | stuff_err | crc_err | form_err | drop_ovf) begin
        k = rx_push ? EV_PUSH : drop_ovf ? EV_DROP :
            crc_err ? EV_CRC : form_err ? EV_FORM : EV_STUFF;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_event act_kind=%0d exp=none", k);
        end else begin
          e  = sb.pop_front();
          nm = sb_nm.pop_front();
          if (e.kind == k && (k != EV_PUSH || e.frame === rx_frame))
            passed++;
          else
            $display("FAIL %s act_kind=%0d act=%h exp_kind=%0d exp=%h",
                     nm, k, rx_frame, e.kind, e.frame);
        end
      end
    end
  endtask

  task automatic build(input logic [10:0] id, input logic rtr,
                       input logic ide, input logic [3:0] dlc,
                       input logic [63:0] data, input int flip,
                       input int eof_bad);
    bit          raw[$];
    logic [14:0] c;
    int          nb, run;
    bit          last;
    raw = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : (dlc > 4'd8 ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
    c = '0;
    foreach (raw[i])
      c = {c[13:0], 1'b0} ^ (((raw[i] ^ c[14]) != 0) ? 15'h4599 : 15'h0);
    good_crc = c;
    if (flip >= 0) c[flip] = ~c[flip];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    tx   = {};
    run  = 0;
    last = 1'b1;
    foreach (raw[i]) begin
      if (run == 5) begin
        tx.push_back(!last);
        last = !last;
        run  = 1;
      end
      tx.push_back(raw[i]);
      if (raw[i] == last) run++;
      else begin
        run  = 1;
        last = raw[i];
      end
    end
    if (run == 5) tx.push_back(!last);
    repeat (3) tx.push_back(1'b1);
    for (int i = 0; i < 7; i++) tx.push_back(i == eof_bad ? 1'b0 : 1'b1);
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n && i < tx.size(); i++) begin
      can_rx = tx[i];
      repeat (CPB) @(negedge GCLK);
    end
    can_rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    can_rx = 1'b1;
    repeat (n * CPB) @(negedge GCLK);
  endtask

  function automatic logic [107:0] flags();
    return 108'({rx_push, ack_drive, bus_idle, stuff_err,
                 crc_err, form_err, drop_ovf});
  endfunction

  logic [107:0] fa;
  int           a0;

  initial begin
    fork
      monitor();
    join_none
    repeat (4) @(negedge GCLK);
    check("rst_flags", flags(), 108'h0);
    check("rst_frame", rx_frame, 108'h0);
    RES = 1'b1;
    idle_bits(12);
    check("bus_idle_after_11", 108'(bus_idle), 108'h1);

    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1, -1);
    send_n(26);
    RES = 1'b0;
    @(negedge GCLK);
    check("midreset_flags", flags(), 108'h0);
    check("midreset_frame", rx_frame, 108'h0);
    RES = 1'b1;
    idle_bits(12);
    check("bus_idle_after_reset", 108'(bus_idle), 108'h1);

    fa = {11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, good_crc, 13'h0};
    expect_ev("frame_a_push", EV_PUSH, fa);
    a0 = ack_cyc;
    send_n(tx.size());
    check("frame_a_ack_cycles", 108'(ack_cyc - a0), 108'(CPB));
    idle_bits(12);

    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 3, -1);
    expect_ev("crc_flip_err", EV_CRC, '0);
    a0 = ack_cyc;
    send_n(tx.size());
    check("crc_flip_no_ack", 108'(ack_cyc - a0), 108'h0);
    idle_bits(12);

    tx = {};
    repeat (7) tx.push_back(1'b0);
    expect_ev("six_dominant_stuff", EV_STUFF, '0);
    send_n(tx.size());
    idle_bits(12);
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1, -1);
    expect_ev("after_stuff_push", EV_PUSH, fa);
    send_n(tx.size());
    idle_bits(2);

    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1, 2);
    expect_ev("eof3_form", EV_FORM, '0);
    send_n(tx.size());
    idle_bits(12);

    build(11'h123, 1'b0, 1'b1, 4'd2, 64'hABCD_0000_0000_0000, -1, -1);
    a0 = ack_cyc;
    send_n(tx.size());
    check("ide_no_ack", 108'(ack_cyc - a0), 108'h0);
    idle_bits(12);

    q_full = 1'b1;
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1, -1);
    expect_ev("qfull_drop", EV_DROP, '0);
    send_n(tx.size());
    q_full = 1'b0;
    idle_bits(2);

    build(11'h2A5, 1'b1, 1'b0, 4'd8, 64'hDEAD_BEEF_0123_4567, -1, -1);
    expect_ev("rtr_dlc8_push", EV_PUSH,
              {11'h2A5, 1'b1, 4'd8, 64'h0, good_crc, 13'h0});
    send_n(tx.size());
    idle_bits(4);

    check("events_pending", 108'(sb.size()), 108'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
